// File: rtl/exwb_redirect_buffer.sv
// EX/WB pipeline register with branch/jump resolution, PC redirect and squash.
// Optional BRANCH_STATS_EN adds taken_count_out / squash_count_out.
module exwb_redirect_buffer #(
  parameter int DATA_W      = 32,
  parameter int RD_W        = 6,
  parameter int FLUSH_DEPTH = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              stall_in,
  input  logic              RegWrt_in,
  input  logic              MemToReg_in,
  input  logic              PCtoReg_in,
  input  logic              MemRead_in,
  input  logic              MemWrt_in,
  input  logic              Branch_Neg_in,
  input  logic              Branch_Zero_in,
  input  logic              Jump_in,
  input  logic              JumpMem_in,
  input  logic [DATA_W-1:0] rs_in,
  input  logic [DATA_W-1:0] rt_in,
  input  logic [DATA_W-1:0] PCSE_in,
  input  logic [RD_W-1:0]   rd_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic              alu_zero_in,
  input  logic              alu_neg_in,
  input  logic [DATA_W-1:0] mem_rdata_in,
  output logic              RegWrt_out,
  output logic              MemToReg_out,
  output logic              PCtoReg_out,
  output logic              MemRead_out,
  output logic              MemWrt_out,
  output logic [DATA_W-1:0] alu_result_out,
  output logic [DATA_W-1:0] rt_out,
  output logic [DATA_W-1:0] PCSE_out,
  output logic [RD_W-1:0]   rd_out,
  output logic              redirect_out,
  output logic [DATA_W-1:0] redirect_target_out,
  output logic              flush_out,
`ifdef BRANCH_STATS_EN
  output logic [15:0]       taken_count_out,
  output logic [15:0]       squash_count_out,
`endif
  output logic              busy_out
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    JM_WAIT = 2'd1,
    SQUASH  = 2'd2
  } state_t;

  typedef struct packed {
    logic              regwrt;
    logic              memtoreg;
    logic              pctoreg;
    logic              memread;
    logic              memwrt;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] rt;
    logic [DATA_W-1:0] pcse;
    logic [RD_W-1:0]   rd;
  } ex_wb_t;

  localparam logic [2:0] LOAD = 3'(FLUSH_DEPTH);

  state_t            state;
  state_t            state_nx;
  logic [2:0]        cnt;
  logic [2:0]        cnt_nx;
  logic              taken;
  logic              pass;
  logic              redir_nx;
  logic [DATA_W-1:0] target_nx;
  ex_wb_t            wb_in;
  ex_wb_t            wb_nx;
  ex_wb_t            wb_q;
  logic              redir_q;
  logic [DATA_W-1:0] target_q;

  assign taken = Jump_in
               | (Branch_Zero_in & alu_zero_in)
               | (Branch_Neg_in  & alu_neg_in);

  assign wb_in = '{
    regwrt:   RegWrt_in,
    memtoreg: MemToReg_in,
    pctoreg:  PCtoReg_in,
    memread:  MemRead_in,
    memwrt:   MemWrt_in,
    alu:      alu_result_in,
    rt:       rt_in,
    pcse:     PCSE_in,
    rd:       rd_in
  };

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= RUN;
      cnt   <= 3'd0;
    end else if (!stall_in) begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      RUN: begin
        if (taken) begin
          state_nx = SQUASH;
          cnt_nx   = LOAD;
        end else if (JumpMem_in) begin
          state_nx = JM_WAIT;
        end
      end
      JM_WAIT: begin
        state_nx = SQUASH;
        cnt_nx   = LOAD;
      end
      SQUASH: begin
        if (cnt <= 3'd1) begin
          state_nx = RUN;
          cnt_nx   = 3'd0;
        end else begin
          cnt_nx = cnt - 3'd1;
        end
      end
      default: begin
        state_nx = RUN;
        cnt_nx   = 3'd0;
      end
    endcase
  end

  // Anything outside RUN turns the sampled instruction into a bubble.
  always_comb begin
    pass      = (state == RUN);
    redir_nx  = 1'b0;
    target_nx = rs_in;
    wb_nx     = '0;
    unique case (1'b1)
      (state == RUN): begin
        redir_nx = taken;
        wb_nx    = wb_in;
      end
      (state == JM_WAIT): begin
        redir_nx  = 1'b1;
        target_nx = mem_rdata_in;
      end
      default: begin
        redir_nx = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wb_q     <= '0;
      redir_q  <= 1'b0;
      target_q <= '0;
    end else if (stall_in) begin
      redir_q <= 1'b0;
    end else begin
      wb_q    <= wb_nx;
      redir_q <= redir_nx;
      if (redir_nx) begin
        target_q <= target_nx;
      end
    end
  end

`ifdef BRANCH_STATS_EN
  logic [15:0] taken_q;
  logic [15:0] squash_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      taken_q  <= 16'd0;
      squash_q <= 16'd0;
    end else if (!stall_in) begin
      if (redir_nx && taken_q != 16'hFFFF) begin
        taken_q <= taken_q + 16'd1;
      end
      if (!pass && squash_q != 16'hFFFF) begin
        squash_q <= squash_q + 16'd1;
      end
    end
  end

  assign taken_count_out  = taken_q;
  assign squash_count_out = squash_q;
`endif

  assign RegWrt_out          = wb_q.regwrt;
  assign MemToReg_out        = wb_q.memtoreg;
  assign PCtoReg_out         = wb_q.pctoreg;
  assign MemRead_out         = wb_q.memread;
  assign MemWrt_out          = wb_q.memwrt;
  assign alu_result_out      = wb_q.alu;
  assign rt_out              = wb_q.rt;
  assign PCSE_out            = wb_q.pcse;
  assign rd_out              = wb_q.rd;
  assign redirect_out        = redir_q;
  assign redirect_target_out = target_q;
  assign flush_out           = (state == SQUASH);
  assign busy_out            = (state != RUN);

endmodule

// File: doc/exwb_redirect_buffer.md
Name: exwb_redirect_buffer

Overview:
- Consumer end of the ID/EX pipeline register: accepts ID/EX control and data outputs plus EX-stage ALU results.
- Resolves branch/jump decisions and drives a PC redirect toward IF.
- Squashes wrong-path instructions behind a taken control transfer.
- Registers surviving control and data into the EX/WB pipeline register.

Parameters:
DATA_W, 32, datapath width (rs, rt, PCSE, ALU result, mem data)
RD_W, 6, destination register index width
FLUSH_DEPTH, 2, younger instructions squashed after a taken transfer (1..7)

Ports:
clock  input  1  rising-edge clock
reset_n  input  1  synchronous active-low reset
stall_in  input  1  hold all state and outputs this cycle
RegWrt_in, MemToReg_in, PCtoReg_in, MemRead_in, MemWrt_in  input  1 each  ID/EX control
Branch_Neg_in, Branch_Zero_in, Jump_in, JumpMem_in  input  1 each  ID/EX control-transfer type
rs_in, rt_in, PCSE_in  input  DATA_W each  ID/EX operands and PC+sign-extended value
rd_in  input  RD_W  destination register
alu_result_in  input  DATA_W  EX ALU output
alu_zero_in, alu_neg_in  input  1 each  ALU flags
mem_rdata_in  input  DATA_W  data-memory read data (JumpMem target)
RegWrt_out, MemToReg_out, PCtoReg_out, MemRead_out, MemWrt_out  output  1 each  registered control to WB
alu_result_out, rt_out, PCSE_out  output  DATA_W each  registered data to WB
rd_out  output  RD_W  registered destination
redirect_out  output  1  one-cycle pulse: load PC from target
redirect_target_out  output  DATA_W  new PC value
flush_out  output  1  high while squashing; IF/ID and ID/EX insert bubbles
busy_out  output  1  high in any state other than RUN

Behaviour:
- Reset (reset_n low at clock edge): every output 0, state RUN, squash counter 0. Reset overrides stall_in. Reset mid-SQUASH or mid-JM_WAIT returns to RUN with no pending redirect.
- Latency: one cycle, input at edge N to output after edge N.
- stall_in high (not in reset): all registers, state, and counter hold; redirect_out forced 0. When stall and a taken transfer coincide, stall wins and the transfer is evaluated on the first unstalled cycle.
- Taken = Jump_in | (Branch_Zero_in & alu_zero_in) | (Branch_Neg_in & alu_neg_in). JumpMem_in is handled separately.
- States:
  - RUN: instruction passes to outputs unchanged.
    - If taken: redirect_out=1, redirect_target_out=rs_in, load counter=FLUSH_DEPTH, go SQUASH.
    - If JumpMem_in: go JM_WAIT; redirect is not issued yet.
  - JM_WAIT (1 cycle): outputs a bubble; redirect_out=1, redirect_target_out=mem_rdata_in; load counter=FLUSH_DEPTH; go SQUASH.
  - SQUASH: flush_out=1; incoming instruction becomes a bubble (all control outputs 0; data outputs don't-care but driven 0). Incoming Jump/Branch/JumpMem are ignored. Counter decrements each unstalled cycle; at 1 -> RUN.
- PCtoReg_in with RegWrt_in: instruction passes through; WB selects PCSE_out. The buffer only registers values and does no selection.
- Branch instructions themselves pass to WB with their own RegWrt (normally 0).
- The redirect_out pulse is never longer than one cycle. redirect_target_out holds its last value until the next redirect.

Optional Feature:
- Macro BRANCH_STATS_EN adds outputs taken_count_out[15:0] and squash_count_out[15:0].
  - taken_count_out counts redirects issued. squash_count_out counts bubbles inserted, JM_WAIT included.
  - Both counters saturate at 16'hFFFF, reset to 0, and freeze under stall.
- Without the macro these ports and counters do not exist; core behaviour is identical.

Test Plan:
- Reset: reset_n=0 with all inputs 1 -> all outputs 0, busy_out=0; hold reset with stall_in=1 -> still 0.
- Passthrough: RegWrt=1, rd=6'd5, alu_result=32'h1234, no branch -> next cycle RegWrt_out=1, rd_out=5, alu_result_out=32'h1234, flush_out=0.
- BRZ taken: Branch_Zero=1, alu_zero=1, rs=32'h40 -> redirect_out pulse 1 cycle, target 32'h40. Next 2 instructions (RegWrt=1) emerge with RegWrt_out=0, flush_out=1 for 2 cycles, then RUN.
- BRN not taken: Branch_Neg=1, alu_neg=0 -> no redirect, flush_out stays 0, following instruction passes intact.
- JumpMem: JumpMem=1, mem_rdata_in=32'h88 the following cycle -> JM_WAIT bubble, then redirect to 32'h88 and 2 squash cycles (3 bubbles total).
- Stall/reset corner: Jump=1 with stall_in=1 for 3 cycles -> no redirect until stall drops, then redirect. Then assert reset_n=0 during SQUASH -> state RUN, flush_out=0 next cycle.
